// File: rtl/ddr_wr_framer_if.sv
// ddr_wr_framer_if: bus between the DDR mode engine / SDA pad logic and the write framer
// Ports (all signals, named from the framer's point of view):
//   i_start, i_bit_tick, i_cmd_word, i_word_cnt, i_regf_base  : frame request and bit pacing
//   i_regf_rd_data, i_sda                                     : register-file data, synchronised SDA
//   o_sda, o_sda_oe, o_pp_od                                  : SDA pad drive
//   o_regf_rd_en, o_regf_addr                                 : register-file read port
//   o_busy, o_done, o_nack, o_words_sent                      : frame status
// slave is the framer side, master is the engine/testbench side.
interface ddr_wr_framer_if #(
  parameter int ADDR_W = 5,
  parameter int WCNT_W = 4
);
  logic              i_start;
  logic              i_bit_tick;
  logic [15:0]       i_cmd_word;
  logic [WCNT_W-1:0] i_word_cnt;
  logic [ADDR_W-1:0] i_regf_base;
  logic [15:0]       i_regf_rd_data;
  logic              i_sda;
  logic              o_sda;
  logic              o_sda_oe;
  logic              o_pp_od;
  logic              o_regf_rd_en;
  logic [ADDR_W-1:0] o_regf_addr;
  logic              o_busy;
  logic              o_done;
  logic              o_nack;
  logic [WCNT_W-1:0] o_words_sent;
  modport slave (
    input  i_start, i_bit_tick, i_cmd_word, i_word_cnt, i_regf_base, i_regf_rd_data, i_sda,
    output o_sda, o_sda_oe, o_pp_od, o_regf_rd_en, o_regf_addr, o_busy, o_done, o_nack, o_words_sent
  );
  modport master (
    output i_start, i_bit_tick, i_cmd_word, i_word_cnt, i_regf_base, i_regf_rd_data, i_sda,
    input  o_sda, o_sda_oe, o_pp_od, o_regf_rd_en, o_regf_addr, o_busy, o_done, o_nack, o_words_sent
  );
endinterface

// File: rtl/ddr_wr_framer.sv
// ddr_wr_framer: serialises one HDR-DDR write frame (command, ACK slot, N data words, CRC-5) onto SDA
// Ports:
//   i_sys_clk, i_sys_rst : clock, synchronous active-high reset
//   bus (slave)          : start/done handshake, bit tick, register-file read port, SDA pad drive
// Optional feature macro DDR_ACK_CHECK_EN: when defined the ACK slot samples i_sda and a NACK
// aborts the frame; when undefined every ACK slot counts as ACK and o_nack stays 0.
module ddr_wr_framer #(
  parameter int MAX_WORDS = 8,
  parameter int ADDR_W    = 5,
  parameter int WCNT_W    = $clog2(MAX_WORDS + 1)
) (
  input logic           i_sys_clk,
  input logic           i_sys_rst,
  ddr_wr_framer_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, CMD_PRE, CMD, CMD_PAR, ACK_DRV, ACK_SAMP,
    DATA_PRE, DATA, DATA_PAR, CRC_PRE, CRC_TOK, CRC_VAL
  } state_t;
  state_t            st_q, st_d;
  logic [4:0]        cnt_q, cnt_d, len, crc_q, crc_d, crc_sh;
  logic [15:0]       cmd_q, cmd_d, wd_q, wd_d;
  logic [WCNT_W-1:0] nw_q, nw_d, ws_q, ws_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic              rd_en_q, rd_en_d, ld_q, ld_d, done_q, done_d, nack_q, nack_d;
  logic              last, ack, sda;

  function automatic logic par(input logic [15:0] w, input logic second);
    return second ? ~^(w & 16'h5555) : ^(w & 16'hAAAA);
  endfunction

`ifdef DDR_ACK_CHECK_EN
  assign ack = ~bus.i_sda;
`else
  assign ack = 1'b1;
`endif

  assign crc_sh = crc_q << cnt_q[2:0];

  always_comb begin
    len = (st_q == CMD || st_q == DATA) ? 5'd16 :
          (st_q == CRC_VAL) ? 5'd5 :
          (st_q == CRC_TOK) ? 5'd4 :
          (st_q == ACK_DRV || st_q == ACK_SAMP) ? 5'd1 : 5'd2;
    last = bus.i_bit_tick && cnt_q == len - 5'd1;
    // both 2-bit preambles that start with 0 are "0,1", i.e. the bit index itself
    sda = (st_q == CMD_PRE || st_q == CRC_PRE) ? cnt_q[0] :
          (st_q == CMD) ? cmd_q[4'd15 - cnt_q[3:0]] :
          (st_q == DATA) ? wd_q[4'd15 - cnt_q[3:0]] :
          (st_q == CMD_PAR) ? par(cmd_q, cnt_q[0]) :
          (st_q == DATA_PAR) ? par(wd_q, cnt_q[0]) :
          (st_q == CRC_TOK) ? ~cnt_q[1] :
          (st_q == CRC_VAL) ? crc_sh[4] : 1'b1;
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = (st_q == IDLE || last) ? 5'd0 : cnt_q + {4'd0, bus.i_bit_tick};
    cmd_d   = cmd_q;
    nw_d    = nw_q;
    base_d  = base_q;
    addr_d  = addr_q;
    ws_d    = ws_q;
    rd_en_d = 1'b0;
    ld_d    = rd_en_q;
    // read data is valid the cycle after the strobe
    wd_d    = ld_q ? bus.i_regf_rd_data : wd_q;
    done_d  = 1'b0;
    nack_d  = 1'b0;
    crc_d   = (st_q == DATA && bus.i_bit_tick) ?
              {crc_q[3:0], 1'b0} ^ ({5{crc_q[4] ^ sda}} & 5'h05) : crc_q;
    case (st_q)
      IDLE: if (bus.i_start) begin
        st_d   = CMD_PRE;
        cmd_d  = bus.i_cmd_word;
        nw_d   = (bus.i_word_cnt > WCNT_W'(MAX_WORDS)) ? WCNT_W'(MAX_WORDS) : bus.i_word_cnt;
        base_d = bus.i_regf_base;
        ws_d   = '0;
        crc_d  = 5'h1F;
      end
      CMD_PRE: if (last) st_d = CMD;
      CMD:     if (last) st_d = CMD_PAR;
      CMD_PAR: if (last) begin
        st_d    = ACK_DRV;
        rd_en_d = 1'b1;
        addr_d  = base_q;
      end
      ACK_DRV: if (last) st_d = ACK_SAMP;
      ACK_SAMP: if (last) begin
        st_d   = (ack && nw_q != '0) ? DATA : IDLE;
        done_d = !(ack && nw_q != '0);
        nack_d = ~ack;
      end
      DATA: if (last) st_d = DATA_PAR;
      // ws_q doubles as the index of the word currently on the wire
      DATA_PAR: if (last) begin
        ws_d = ws_q + 1'b1;
        if (ws_d < nw_q) begin
          st_d    = DATA_PRE;
          rd_en_d = 1'b1;
          addr_d  = base_q + ADDR_W'(ws_d);
        end else begin
          st_d = CRC_PRE;
        end
      end
      DATA_PRE: if (last) st_d = DATA;
      CRC_PRE:  if (last) st_d = CRC_TOK;
      CRC_TOK:  if (last) st_d = CRC_VAL;
      CRC_VAL: if (last) begin
        st_d   = IDLE;
        done_d = 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      wd_q    <= '0;
      nw_q    <= '0;
      ws_q    <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      crc_q   <= 5'h1F;
      rd_en_q <= 1'b0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      wd_q    <= wd_d;
      nw_q    <= nw_d;
      ws_q    <= ws_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      crc_q   <= crc_d;
      rd_en_q <= rd_en_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  assign bus.o_sda        = sda;
  assign bus.o_sda_oe     = st_q != IDLE && st_q != ACK_SAMP;
  assign bus.o_pp_od      = st_q != IDLE && st_q != ACK_SAMP && st_q != ACK_DRV;
  assign bus.o_regf_rd_en = rd_en_q;
  assign bus.o_regf_addr  = addr_q;
  assign bus.o_busy       = st_q != IDLE;
  assign bus.o_done       = done_q;
  assign bus.o_nack       = nack_q;
  assign bus.o_words_sent = ws_q;
endmodule

// File: tb/tb_ddr_wr_framer.sv
// tb_ddr_wr_framer: randomized scoreboard bench for ddr_wr_framer against a frame-level reference model
module tb_ddr_wr_framer;
  typedef struct {
    int nbits;
    int nack;
    int ws;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr_wr_framer_if #(.ADDR_W(5), .WCNT_W(4)) bus ();
  ddr_wr_framer #(.MAX_WORDS(8), .ADDR_W(5), .WCNT_W(4)) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .bus(bus)
  );

  int nerr = 0;
  int nchk = 0;
  int tick_mode = 0;
  logic [15:0] regf [32];
  int bitq[$];
  int rdq[$];
  frame_t frq[$];
  int cur_bits = 0;
  bit done_next = 0;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected bit codes: 0/1 push-pull driven, 2 open-drain driven 1, 3 released
  task automatic model(input logic [15:0] cmd, input int wc, input int base, input bit sda_v);
    int n;
    bit nk;
    logic [15:0] w;
    bit d[$];
    frame_t f;
    int l;
    n = (wc > 8) ? 8 : wc;
`ifdef DDR_ACK_CHECK_EN
    nk = sda_v;
`else
    nk = 1'b0;
`endif
    bitq.push_back(0);
    bitq.push_back(1);
    for (int i = 15; i >= 0; i--) bitq.push_back(int'(cmd[i]));
    bitq.push_back(int'(^(cmd & 16'hAAAA)));
    bitq.push_back(int'(~^(cmd & 16'h5555)));
    bitq.push_back(2);
    bitq.push_back(3);
    rdq.push_back(base % 32);
    if (!nk && n > 0) begin
      for (int k = 0; k < n; k++) begin
        if (k > 0) begin
          bitq.push_back(1);
          bitq.push_back(1);
          rdq.push_back((base + k) % 32);
        end
        w = regf[(base + k) % 32];
        for (int i = 15; i >= 0; i--) begin
          bitq.push_back(int'(w[i]));
          d.push_back(w[i]);
        end
        bitq.push_back(int'(^(w & 16'hAAAA)));
        bitq.push_back(int'(~^(w & 16'h5555)));
      end
      // CRC-5 as the remainder of the augmented message, initial value folded into the leading bits
      for (int i = 0; i < 5; i++) d[i] = ~d[i];
      l = d.size();
      for (int i = 0; i < 5; i++) d.push_back(1'b0);
      for (int i = 0; i < l; i++)
        if (d[i]) begin
          d[i] = 1'b0;
          d[i+3] = ~d[i+3];
          d[i+5] = ~d[i+5];
        end
      bitq.push_back(0); bitq.push_back(1);
      bitq.push_back(1); bitq.push_back(1); bitq.push_back(0); bitq.push_back(0);
      for (int i = 0; i < 5; i++) bitq.push_back(int'(d[l+i]));
    end
    f.nbits = (nk || n == 0) ? 22 : 22 + 18 * n + 2 * (n - 1) + 11;
    f.nack = int'(nk);
    f.ws = nk ? 0 : n;
    frq.push_back(f);
  endtask

  initial begin
    bus.i_bit_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_bit_tick = (tick_mode == 0) ? 1'b1 : ($urandom_range(tick_mode, 0) == 0);
    end
  end

  initial begin
    bit pend;
    int pa;
    pend = 1'b0;
    pa = 0;
    bus.i_regf_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_regf_rd_data = pend ? regf[pa] : 16'($urandom);
      pend = bus.o_regf_rd_en;
      pa = int'(bus.o_regf_addr);
    end
  end

  always @(negedge clk) begin
    int act;
    frame_t f;
    if (rst) begin
      bitq.delete();
      rdq.delete();
      frq.delete();
      cur_bits = 0;
      done_next = 0;
    end else begin
      if (done_next) begin
        check("done_after_last_tick", int'(bus.o_done), 1);
        done_next = 0;
      end
      if (bus.o_done) begin
        if (frq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          f = frq.pop_front();
          check("frame_bits", cur_bits, f.nbits);
          check("nack_at_done", int'(bus.o_nack), f.nack);
          check("words_sent_at_done", int'(bus.o_words_sent), f.ws);
          check("busy_at_done", int'(bus.o_busy), 0);
          check("oe_at_done", int'(bus.o_sda_oe), 0);
        end
        cur_bits = 0;
      end
      if (bus.o_regf_rd_en) begin
        if (rdq.size() == 0) check("unexpected_read", int'(bus.o_regf_addr), -1);
        else check("read_addr", int'(bus.o_regf_addr), rdq.pop_front());
      end
      if (bus.o_busy && bus.i_bit_tick) begin
        act = !bus.o_sda_oe ? 3 : !bus.o_pp_od ? (bus.o_sda ? 2 : 4) : int'(bus.o_sda);
        if (bitq.size() == 0) check("unexpected_bit", act, -1);
        else check("sda_bit", act, bitq.pop_front());
        cur_bits++;
        if (frq.size() != 0 && cur_bits == frq[0].nbits) done_next = 1;
      end
    end
  end

  task automatic check_reset();
    check("rst_sda", int'(bus.o_sda), 1);
    check("rst_oe", int'(bus.o_sda_oe), 0);
    check("rst_pp_od", int'(bus.o_pp_od), 0);
    check("rst_rd_en", int'(bus.o_regf_rd_en), 0);
    check("rst_addr", int'(bus.o_regf_addr), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_nack", int'(bus.o_nack), 0);
    check("rst_words_sent", int'(bus.o_words_sent), 0);
  endtask

  task automatic start_frame(input logic [15:0] cmd, input int wc, input int base, input bit sda_v);
    int g;
    g = 0;
    while (bus.o_busy && g < 20000) begin
      @(posedge clk);
      #1;
      g++;
    end
    model(cmd, wc, base, sda_v);
    bus.i_cmd_word = cmd;
    bus.i_word_cnt = 4'(wc);
    bus.i_regf_base = 5'(base);
    bus.i_sda = sda_v;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", int'(bus.o_busy), 1);
    check("first_cmd_pre_bit", int'(bus.o_sda), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.o_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    bus.i_start = 1'b0;
    bus.i_cmd_word = '0;
    bus.i_word_cnt = '0;
    bus.i_regf_base = '0;
    bus.i_sda = 1'b0;
    for (int i = 0; i < 32; i++) regf[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_mode = 0;
    start_frame(16'h0000, 0, 0, 1'b0);
    wait_done();
    tick_mode = 1;
    regf[7] = 16'hFFFF;
    start_frame(16'hA5C3, 1, 7, 1'b0);
    wait_done();
    tick_mode = 2;
    start_frame(16'h1234, 3, 4, 1'b0);
    wait_done();
    tick_mode = 1;
    start_frame(16'h8001, 2, 3, 1'b1);
    wait_done();
    tick_mode = 0;
    start_frame(16'h0F0F, 4, 10, 1'b0);
    n = 0;
    while (bus.o_words_sent != 4'd1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    t = 0;
    while (t < 6 && n < 20000) begin
      @(negedge clk);
      if (bus.i_bit_tick) t++;
      n++;
    end
    if (n >= 20000) check("word2_timeout", 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_frame(16'hBEEF, 2, 30, 1'b0);
    wait_done();
    tick_mode = 1;
    start_frame(16'h5A5A, 15, 28, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    bus.i_cmd_word = 16'hFFFF;
    bus.i_word_cnt = 4'd2;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_done();
    for (int r = 0; r < 12; r++) begin
      tick_mode = int'($urandom_range(3, 0));
      for (int i = 0; i < 32; i++) regf[i] = 16'($urandom);
      start_frame(16'($urandom), int'($urandom_range(10, 0)), int'($urandom_range(31, 0)), 1'($urandom));
      wait_done();
    end
    repeat (5) @(posedge clk);
    check("bits_drained", bitq.size(), 0);
    check("reads_drained", rdq.size(), 0);
    check("frames_drained", frq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
